cpu_ctrl_fsm: RTL and testbench
===============================

# cpu_ctrl_fsm

Multi-cycle control unit for the 32-bit, 3-bit-opcode processor. It fetches instructions over a shared memory handshake, presents them to the instruction decoder, and sequences execute, memory and writeback. It owns the 16-bit program counter and instruction register, and drives the register-file, ALU and memory control strobes of the datapath.

## Interface
- No parameters; widths are fixed by the ISA.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; permits the start of a new instruction fetch
- mem_req  out  1  memory request; held until accepted
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr  out  16  memory address, qualified by mem_req
- mem_ack  in  1  one-cycle acceptance; on reads mem_rdata is valid in the same cycle
- mem_rdata  in  32  memory read data
- ir  out  32  instruction register, feeds the decoder
- opcode  in  3  decoded opcode, inst[31:29] of ir
- addr  in  16  decoded address/immediate field
- cmp_eq  in  1  datapath compare result (R[reg0] == R[reg1]), valid in EXEC
- pc  out  16  program counter
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 PASS_B
- alu_src_imm  out  1  ALU operand B = addr instead of R[reg2]
- wb_sel  out  1  0 = ALU result, 1 = load data
- load_data  out  32  captured load data
- rf_we  out  1  register-file write enable for R[reg0]
- instr_done  out  1  one-cycle pulse when an instruction retires
- busy  out  1  high in every state except IDLE

## Operation
- ISA semantics:
  - 0 LOAD: R0 <= mem[addr].
  - 1 STORE: mem[addr] <= R0.
  - 2 ADDI: R0 <= R1 + imm.
  - 3 BNE: if R0 != R1, pc <= addr.
  - 4 ADD: R0 <= R1 + R2.
  - 5 SUB: R0 <= R1 - R2.
  - 6 AND: R0 <= R1 & R2.
  - 7 MOV: R0 <= R2.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE: no outputs active. When run=1, go to FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ack: ir <= mem_rdata, pc <= pc+1 (modulo 2^16, so FFFF wraps to 0000), go to DECODE.
- DECODE: one cycle for register-file read. No strobes.
- EXEC:
  - Opcode 0/1 → MEM.
  - Opcode 3: if cmp_eq=0, pc <= addr. Pulse instr_done, go to FETCH (or IDLE if run=0).
  - Opcodes 2 and 4–7 → WB.
- MEM: mem_req=1, mem_addr=addr, mem_we=(opcode==1).
  - On mem_ack for a load: load_data <= mem_rdata, go to WB.
  - On mem_ack for a store: pulse instr_done, go to FETCH/IDLE.
- WB: rf_we=1 for exactly one cycle, pulse instr_done, go to FETCH/IDLE.
- alu_op / alu_src_imm are valid in EXEC and WB; they are don't-care elsewhere.
  - Opcode 2: alu_op=00, alu_src_imm=1.
  - Opcode 4: alu_op=00. Opcode 5: 01. Opcode 6: 10. Opcode 7: 11. All with alu_src_imm=0.
- wb_sel=1 only in WB for opcode 0.
- run is sampled only at IDLE and at retirement. Deasserting run mid-instruction completes that instruction, then returns to IDLE.
- mem_ack is ignored outside FETCH/MEM and when mem_req=0.

## Timing
- Reset values: state IDLE, pc=0000, ir=0, load_data=0. All strobes (mem_req, mem_we, rf_we, instr_done, busy) are 0; mem_addr=0.
- rst has priority over every event, including an mem_ack arriving in the same cycle. mem_req drops in the cycle after the reset edge, and any in-flight access is abandoned.
- mem_req rises in the cycle after entry to FETCH/MEM. mem_addr and mem_we stay stable while mem_req=1. mem_req falls in the cycle after mem_ack.
- Latency with zero-wait memory (mem_ack in the first request cycle), counted from FETCH entry:
  - ALU ops: 4 cycles.
  - BNE: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds one.
- instr_done coincides with the final-state cycle (rf_we for WB). A new FETCH begins the next cycle.
- Taken branch: pc takes addr at the EXEC edge, overriding the earlier increment. The next fetch uses addr.

## Test plan
- Reset then run=1, memory returns 0x88100000 (ADD r8,r2,r0) with zero wait.
  - Required: FETCH at pc=0000, pc=0001 after ack.
  - rf_we for exactly one cycle at cycle 4, alu_op=00, instr_done with it.
- LOAD 0x0500ABCD with memory ack delayed 3 cycles on the MEM access.
  - Required: mem_addr=ABCD, mem_we=0 held stable until ack.
  - load_data captured, wb_sel=1 in WB.
- STORE 0x2300_1234: mem_we=1, mem_addr=1234.
  - Required: no rf_we, instr_done on the ack cycle.
- BNE 0x6108_0040: with cmp_eq=0 the next fetch is at 0040; with cmp_eq=1 the next fetch is at pc+1.
- pc=FFFF fetch: pc becomes 0000 after ack.
  - run dropped in DECODE → instruction retires, then IDLE with busy=0.
- rst asserted in MEM together with mem_ack.
  - Required: next cycle state IDLE, mem_req=0, pc=0000, no rf_we/instr_done.

Source files
------------

// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ctrl_fsm
//  Purpose  : Multi-cycle control unit for the 32-bit, 3-bit-opcode processor.
//             Fetches instructions over a shared memory handshake, holds the
//             PC and instruction register, and sequences
//             DECODE / EXEC / MEM / WB while driving the datapath strobes.
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             run                       - permits a new instruction fetch
//             mem_req/we/addr, mem_ack,
//             mem_rdata                 - shared memory handshake
//             ir, opcode, addr, cmp_eq  - decoder / datapath interface
//             pc, alu_op, alu_src_imm,
//             wb_sel, load_data, rf_we  - datapath control
//             instr_done, busy          - retirement pulse, activity flag
//  Revision : 1.0  initial release
// ============================================================================
module cpu_ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  input  logic [2:0]  opcode,
  input  logic [15:0] addr,
  input  logic        cmp_eq,
  output logic [15:0] pc,
  output logic [1:0]  alu_op,
  output logic        alu_src_imm,
  output logic        wb_sel,
  output logic [31:0] load_data,
  output logic        rf_we,
  output logic        instr_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [2:0] C_OP_LOAD  = 3'd0;
  localparam logic [2:0] C_OP_STORE = 3'd1;
  localparam logic [2:0] C_OP_ADDI  = 3'd2;
  localparam logic [2:0] C_OP_BNE   = 3'd3;

  state_t      state;
  logic        done_q;
  logic        accept;
  logic        store_ack;
  logic        bne_exec;
  logic        retire;
  logic [15:0] fetch_addr;

  // An acknowledge only counts while a request is actually outstanding.
  assign accept    = mem_req & mem_ack;
  assign store_ack = (state == S_MEM) & accept & mem_we;
  assign bne_exec  = (state == S_EXEC) & (opcode == C_OP_BNE);
  assign retire    = store_ack | bne_exec | (state == S_WB);

  // A taken branch redirects the very next fetch, overriding the increment.
  assign fetch_addr = (bne_exec & ~cmp_eq) ? addr : pc;

  // A store retires in the same cycle its acknowledge arrives, which a
  // registered pulse cannot express; that one term is combinational.
  assign instr_done = done_q | (store_ack & ~rst);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= 16'h0000;
      ir          <= 32'h0000_0000;
      load_data   <= 32'h0000_0000;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 16'h0000;
      alu_op      <= 2'b00;
      alu_src_imm <= 1'b0;
      wb_sel      <= 1'b0;
      rf_we       <= 1'b0;
      done_q      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Single-cycle strobes fall unless a state below re-asserts them.
      rf_we  <= 1'b0;
      done_q <= 1'b0;
      wb_sel <= 1'b0;

      case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (accept) begin
            ir      <= mem_rdata;
            pc      <= pc + 16'd1;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          state       <= S_EXEC;
          alu_src_imm <= (opcode == C_OP_ADDI);
          // Opcodes 4..7 map directly onto ADD/SUB/AND/PASS_B.
          alu_op      <= opcode[2] ? opcode[1:0] : 2'b00;
          // A branch retires in EXEC, so its pulse is armed here.
          done_q      <= (opcode == C_OP_BNE);
        end
        S_EXEC: begin
          if ((opcode == C_OP_LOAD) || (opcode == C_OP_STORE)) begin
            state    <= S_MEM;
            mem_req  <= 1'b1;
            mem_we   <= (opcode == C_OP_STORE);
            mem_addr <= addr;
          end else if (opcode == C_OP_BNE) begin
            if (!cmp_eq) begin
              pc <= addr;
            end
          end else begin
            state  <= S_WB;
            rf_we  <= 1'b1;
            done_q <= 1'b1;
          end
        end
        S_MEM: begin
          if (accept) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              load_data <= mem_rdata;
              state     <= S_WB;
              rf_we     <= 1'b1;
              done_q    <= 1'b1;
              wb_sel    <= 1'b1;
            end
          end
        end
        S_WB: begin
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // Retirement is the only point besides IDLE where run is sampled.
      if (retire) begin
        if (run) begin
          state    <= S_FETCH;
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= fetch_addr;
        end else begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_ctrl_fsm
//  Purpose  : Self-checking bench for cpu_ctrl_fsm. An ISA-level model turns
//             each issued instruction into expected bus transactions and an
//             expected retirement record; a memory responder serves requests
//             with chosen wait states; a monitor compares DUT activity
//             against the queued expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst, run, mem_ack, cmp_eq;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, wb_sel, rf_we, instr_done, busy, alu_src_imm;
  logic [15:0] mem_addr, pc, addr;
  logic [31:0] ir, load_data;
  logic [2:0]  opcode;
  logic [1:0]  alu_op;

  always #5 clk = ~clk;

  // Instruction decoder stand-in.
  assign opcode = ir[31:29];
  assign addr   = ir[15:0];

  cpu_ctrl_fsm dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir),
    .opcode(opcode), .addr(addr), .cmp_eq(cmp_eq), .pc(pc),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .wb_sel(wb_sel),
    .load_data(load_data), .rf_we(rf_we), .instr_done(instr_done), .busy(busy)
  );

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic        fetch;
  } bus_t;

  typedef struct {
    logic [2:0]  op;
    logic        rf_we;
    logic        wb_sel;
    logic        chk_alu;
    logic [1:0]  alu_op;
    logic        alu_imm;
    logic [31:0] ld;
    logic [15:0] pc_at;
    int          lat;
  } ret_t;

  bus_t        bus_q[$];
  ret_t        ret_q[$];
  logic [31:0] rdq[$];
  int          waitq[$];
  bit          cmp_list[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          fetch_start = 0;
  int          wcnt = 0;
  bit          txn_started = 0;
  bit          ok = 1;
  logic [15:0] mpc;
  ret_t        cur;
  bus_t        curb;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_bus(input logic [15:0] a, input logic we, input logic f);
    bus_t b;
    b.addr = a; b.we = we; b.fetch = f;
    bus_q.push_back(b);
  endtask

  // ISA-level model: one call per instruction, in program order.
  task automatic issue(input logic [31:0] w, input bit c, input int wf,
                       input int wm, input logic [31:0] d);
    ret_t        r;
    logic [2:0]  op;
    logic [15:0] a;
    op = w[31:29];
    a  = w[15:0];
    push_bus(mpc, 1'b0, 1'b1);
    rdq.push_back(w);
    waitq.push_back(wf);
    cmp_list.push_back(c);
    r.op      = op;
    r.pc_at   = mpc + 16'd1;
    r.ld      = d;
    r.rf_we   = (op != 3'd1) && (op != 3'd3);
    r.wb_sel  = (op == 3'd0);
    r.chk_alu = (op == 3'd2) || (op >= 3'd4);
    r.alu_imm = (op == 3'd2);
    case (op)
      3'd5:    r.alu_op = 2'b01;
      3'd6:    r.alu_op = 2'b10;
      3'd7:    r.alu_op = 2'b11;
      default: r.alu_op = 2'b00;
    endcase
    r.lat = (1 + wf) + 1 + 1;
    if (op <= 3'd1) begin
      push_bus(a, op[0], 1'b0);
      waitq.push_back(wm);
      if (op == 3'd0) rdq.push_back(d);
      r.lat += 1 + wm;
    end
    if (r.rf_we) r.lat += 1;
    ret_q.push_back(r);
    mpc = (op == 3'd3 && !c) ? a : mpc + 16'd1;
  endtask

  task automatic issue_random();
    issue($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom);
  endtask

  task automatic run_segment(input int n);
    int target;
    target = done_cnt + n;
    run = 1'b1;
    for (int k = 0; k < 3000 && done_cnt < target - 1; k++) @(posedge clk);
    @(posedge clk);
    #1 run = 1'b0;
    for (int k = 0; k < 3000 && done_cnt < target; k++) @(posedge clk);
    if (done_cnt != target) begin
      check("segment_timeout_retired", 32'(done_cnt), 32'(target));
      ok = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_mem_req", 32'(mem_req), 32'd0);
      end
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory responder and compare-result driver.
  always @(posedge clk) begin
    #1;
    if (mem_req === 1'b1) begin
      if (waitq.size() > 0 && wcnt >= waitq[0]) begin
        mem_ack = 1'b1;
        if (!mem_we && rdq.size() > 0) mem_rdata = rdq.pop_front();
        else mem_rdata = $urandom;
        void'(waitq.pop_front());
        wcnt = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      // Stray acknowledges with no request outstanding must be ignored.
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
      wcnt      = 0;
    end
    if (done_cnt < cmp_list.size()) cmp_eq = cmp_list[done_cnt];
    else cmp_eq = 1'($urandom_range(0, 1));
  end

  // Monitor: retirement scoreboard and bus scoreboard.
  always @(negedge clk) begin
    if (instr_done === 1'b1) begin
      if (ret_q.size() == 0) begin
        check("retire_unexpected", 32'd1, 32'd0);
      end else begin
        cur = ret_q.pop_front();
        check("retire_rf_we", 32'(rf_we), 32'(cur.rf_we));
        check("retire_wb_sel", 32'(wb_sel), 32'(cur.wb_sel));
        check("retire_pc", 32'(pc), 32'(cur.pc_at));
        check("retire_latency", 32'(cyc - fetch_start + 1), 32'(cur.lat));
        if (cur.chk_alu) begin
          check("retire_alu_op", 32'(alu_op), 32'(cur.alu_op));
          check("retire_alu_src_imm", 32'(alu_src_imm), 32'(cur.alu_imm));
        end
        if (cur.op == 3'd0) check("retire_load_data", load_data, cur.ld);
      end
      done_cnt++;
    end else if (rf_we === 1'b1) begin
      check("rf_we_without_retire", 32'(rf_we), 32'd0);
    end
    if (mem_req === 1'b1) begin
      if (bus_q.size() == 0) begin
        check("bus_unexpected_req", 32'd1, 32'd0);
      end else begin
        curb = bus_q[0];
        if (!txn_started) begin
          txn_started = 1;
          if (curb.fetch) fetch_start = cyc;
        end
        check("bus_addr", 32'(mem_addr), 32'(curb.addr));
        check("bus_we", 32'(mem_we), 32'(curb.we));
        if (mem_ack === 1'b1) begin
          void'(bus_q.pop_front());
          txn_started = 0;
        end
      end
    end
  end

  initial begin
    bit found;
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_rdata = '0; cmp_eq = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_ir", ir, 32'd0);
    check("reset_load_data", load_data, 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_rf_we", 32'(rf_we), 32'd0);
    check("reset_instr_done", 32'(instr_done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    mpc = 16'h0000;

    // Directed program covering the named scenarios.
    issue(32'h8810_0000, 1'b0, 0, 0, 32'h0);           // ADD
    issue(32'h0500_ABCD, 1'b0, 0, 3, 32'h1357_9BDF);   // LOAD, 3 wait cycles
    issue(32'h2300_1234, 1'b0, 0, 0, 32'h0);           // STORE
    issue(32'h6108_0040, 1'b0, 0, 0, 32'h0);           // BNE taken -> 0040
    issue(32'h6108_0040, 1'b1, 0, 0, 32'h0);           // BNE not taken -> 0041
    issue(32'h6000_FFFF, 1'b0, 1, 0, 32'h0);           // BNE taken -> FFFF
    issue(32'h4000_0005, 1'b0, 1, 0, 32'h0);           // ADDI at FFFF, pc wraps
    issue(32'hA000_0000, 1'b0, 0, 0, 32'h0);           // SUB at 0000
    run_segment(8);

    for (int s = 0; s < 2 && ok; s++) begin
      for (int i = 0; i < 30; i++) issue_random();
      run_segment(30);
    end

    // Reset arriving together with the load acknowledge in MEM.
    if (ok) begin
      push_bus(mpc, 1'b0, 1'b1);
      rdq.push_back(32'h0500_BEEF);
      waitq.push_back(0);
      push_bus(16'hBEEF, 1'b0, 1'b0);
      rdq.push_back(32'h1234_5678);
      waitq.push_back(2);
      @(posedge clk);
      #1 run = 1'b1;
      found = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (mem_req && mem_ack && !mem_we && mem_addr == 16'hBEEF) begin
          found = 1;
          break;
        end
      end
      check("rst_test_reached_mem_ack", 32'(found), 32'd1);
      #1 rst = 1'b1; run = 1'b0;
      @(negedge clk);
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_mem_req", 32'(mem_req), 32'd0);
      check("midreset_pc", 32'(pc), 32'd0);
      check("midreset_rf_we", 32'(rf_we), 32'd0);
      check("midreset_instr_done", 32'(instr_done), 32'd0);
      check("midreset_load_data", load_data, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("post_reset_mem_req", 32'(mem_req), 32'd0);
    end

    check("leftover_bus_txns", 32'(bus_q.size()), 32'd0);
    check("leftover_retirements", 32'(ret_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
